// File: rtl/rob_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rob_pkg
// Description : Shared entry type and constants for the reorder buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package rob_pkg;

    localparam int ROB_DEPTH = 16;

    localparam logic [1:0] ROB_BRANCH = 2'b00;
    localparam logic [1:0] ROB_STORE  = 2'b01;
    localparam logic [1:0] ROB_REG    = 2'b10;

    // The entry kind is called rtype because "type" is a reserved word.
    typedef struct packed {
        logic [1:0]  rtype;
        logic [31:0] destination;
        logic [31:0] value;
        logic        branch_pred;
        logic        branch_result;
        logic [3:0]  ROB_number;
        logic        ready;
        logic        valid;
    } ROB_entry_t;

endpackage
`default_nettype wire

// File: rtl/reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module      : reorder_buffer
// Description : Circular in-order reorder buffer with CDB writeback, head
//               commit port and two forwarding source-operand lookups.
// Revision    : 1.0 - initial release
// ============================================================================
module reorder_buffer
    import rob_pkg::*;
#(
    parameter int DEPTH = ROB_DEPTH
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        alloc_en,
    input  logic [1:0]  alloc_type,
    input  logic [31:0] alloc_dest,
    input  logic        alloc_pred,
    output logic [3:0]  alloc_rob,
    output logic        full,
    output logic        empty,
    input  logic        cdb_valid,
    input  logic [3:0]  cdb_rob,
    input  logic [31:0] cdb_value,
    input  logic        cdb_br_result,
    input  logic [3:0]  src1_rob,
    input  logic [3:0]  src2_rob,
    output logic        src1_ready,
    output logic        src2_ready,
    output logic [31:0] src1_value,
    output logic [31:0] src2_value,
    output ROB_entry_t  head,
    output logic        rob_head_ready,
    input  logic        rd_en
);

    localparam int               IDX_W      = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] c_ptr_one  = IDX_W'(1);
    localparam logic [IDX_W:0]   c_cnt_one  = (IDX_W + 1)'(1);
    localparam logic [IDX_W:0]   c_cnt_full = (IDX_W + 1)'(DEPTH);

    ROB_entry_t       r_entries [DEPTH];
    logic [IDX_W-1:0] r_head_ptr;
    logic [IDX_W-1:0] r_tail_ptr;
    logic [IDX_W:0]   r_count;

    logic w_alloc_fire;
    logic w_deq_fire;
    logic w_cdb_hit;

    function automatic logic [IDX_W-1:0] tag_idx(input logic [3:0] tag);
        return tag[IDX_W-1:0];
    endfunction

    // {ready, value} for one lookup, forwarding a same-cycle CDB broadcast.
    function automatic logic [32:0] lookup(input ROB_entry_t e, input logic hit,
                                           input logic [31:0] fwd);
        return {e.valid & (e.ready | hit), hit ? fwd : e.value};
    endfunction

    assign full         = (r_count == c_cnt_full);
    assign empty        = (r_count == '0);
    assign alloc_rob    = 4'(r_tail_ptr);
    assign w_alloc_fire = alloc_en & ~full;
    assign w_deq_fire   = rd_en & ~empty;
    assign w_cdb_hit    = cdb_valid & r_entries[tag_idx(cdb_rob)].valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head_ptr <= '0;
            r_tail_ptr <= '0;
            r_count    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i] <= '0;
            end
        end else if (flush) begin
            r_head_ptr <= '0;
            r_tail_ptr <= '0;
            r_count    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i].valid <= 1'b0;
                r_entries[i].ready <= 1'b0;
            end
        end else begin
            if (w_alloc_fire) begin
                r_entries[r_tail_ptr] <= '{rtype:         alloc_type,
                                           destination:   alloc_dest,
                                           value:         32'h0,
                                           branch_pred:   alloc_pred,
                                           branch_result: 1'b0,
                                           ROB_number:    4'(r_tail_ptr),
                                           ready:         1'b0,
                                           valid:         1'b1};
                r_tail_ptr <= r_tail_ptr + c_ptr_one;
            end
            if (w_cdb_hit) begin
                r_entries[tag_idx(cdb_rob)].value         <= cdb_value;
                r_entries[tag_idx(cdb_rob)].branch_result <= cdb_br_result;
                r_entries[tag_idx(cdb_rob)].ready         <= 1'b1;
            end
            if (w_deq_fire) begin
                r_entries[r_head_ptr].valid <= 1'b0;
                r_head_ptr <= r_head_ptr + c_ptr_one;
            end
            case ({w_alloc_fire, w_deq_fire})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    always_comb begin
        head            = r_entries[r_head_ptr];
        head.ROB_number = 4'(r_head_ptr);
    end

    assign rob_head_ready = r_entries[r_head_ptr].valid & r_entries[r_head_ptr].ready;

    assign {src1_ready, src1_value} = lookup(r_entries[tag_idx(src1_rob)],
                                             cdb_valid && (cdb_rob == src1_rob), cdb_value);
    assign {src2_ready, src2_value} = lookup(r_entries[tag_idx(src2_rob)],
                                             cdb_valid && (cdb_rob == src2_rob), cdb_value);

endmodule
`default_nettype wire
